aes_round_seq: RTL and testbench
================================

Name: aes_round_seq

Overview:
- Sequencer for the iterative AES-128 encryption core.
- Accepts one 128-bit plaintext block and applies the initial AddRoundKey itself.
- Then issues NR passes through the external round datapath (SubBytes/MixColumns/AddRoundKey), asserting rnd_last on the final pass so the datapath bypasses MixColumns.
- Fetches round keys from the synchronous-read round-key RAM and returns the ciphertext with a one-cycle done pulse.

Parameters:
- NR, 10: number of rounds; 1..15, limited by the 4-bit key_addr.
- RND_LAT, 2: round datapath latency in clk cycles, from stable rnd_in/rnd_key to a valid rnd_out; 0..7.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to encrypt din; accepted only when ready=1
- ready  out  1  1 in IDLE only
- din  in  128  plaintext; word0 = [127:96]; sampled on the accept cycle
- busy  out  1  1 in every state except IDLE
- done  out  1  one-cycle pulse; dout is valid on this cycle
- dout  out  128  ciphertext register; holds its value until the next done
- key_addr  out  4  round-key RAM address
- key_data  in  128  round key; valid the cycle after key_addr changes
- rnd_in  out  128  state word presented to the round datapath
- rnd_key  out  128  round key presented to the datapath; equals key_data
- rnd_last  out  1  final round, MixColumns bypassed
- rnd_out  in  128  round datapath result

Behaviour:
- Reset: state=IDLE; ready=1; busy=0; done=0; dout=0; key_addr=0; rnd_in=0; rnd_last=0; round counter r=0; cycle counter c=0.
- rst has priority over every transition. Asserting it mid-operation aborts the block: no done pulse, dout is cleared to 0, and the next cycle is IDLE.
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE:
  - on start=1: latch din into st, set key_addr=0, go to LOAD.
  - start=0: stay in IDLE.
- LOAD (1 cycle):
  - st <= st ^ key_data (round key 0).
  - key_addr <= 1, r <= 1, c <= 0, go to ROUND.
- ROUND:
  - Outputs: rnd_in=st, rnd_key=key_data, rnd_last=(r==NR). These must stay stable for the whole round, so key_addr and st do not change before capture.
  - Each cycle, c increments.
  - When c==RND_LAT: st <= rnd_out and c <= 0.
    - If r==NR: go to DONE.
    - Otherwise: r <= r+1, key_addr <= r+1, stay in ROUND. The new key arrives on the next cycle, which is the first cycle of the next round.
  - Each round lasts RND_LAT+1 cycles. RND_LAT=0 gives a combinational round of 1 cycle.
- DONE (1 cycle): done=1, dout=st (dout is registered on entry to DONE), then go to IDLE.
- Latency: with the accept cycle as cycle 0, done is high on cycle 2+NR*(RND_LAT+1). With the defaults this is cycle 32. The earliest next accept is cycle 33; there is no back-to-back overlap.
- Ignored inputs: start while busy, including during DONE, is ignored. No request is queued.
- dout stability: dout never changes except on DONE entry or rst.
- rnd_last=0 outside ROUND. rnd_in keeps the last st value; downstream must ignore rnd_out except at the capture cycle.
- key_addr ranges 0..NR and never wraps.
- Registered outputs are glitch-free; done is a registered output.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: pt=00112233445566778899aabbccddeeff; key RAM preloaded with the expansion of key 000102030405060708090a0b0c0d0e0f; behavioural round model with RND_LAT=2.
  - Required: done exactly at cycle 32 after accept; dout=69c4e0d86a7b0430d8cdb78070b4c55a.
- Address/control trace for the same run:
  - key_addr sequence 0,1,2,…,10, each round address held 3 cycles.
  - rnd_last=1 only during the 10th round.
  - busy=1 for cycles 1..32; ready=1 again on cycle 33.
- start pulses while busy, on cycles 5, 20 and 32:
  - Required: ignored; exactly one done.
  - Then start on cycle 33: accepted, and the second result matches the reference model.
- rst asserted on cycle 15 of an encryption:
  - Required: next cycle state IDLE; ready=1, done=0, dout=0, key_addr=0.
  - No done pulse follows; a subsequent full run gives the correct ciphertext.
- RND_LAT=0, NR=10:
  - Required: done at cycle 12 and the same ciphertext as the C.1 case.
- dout hold: after done, drive random din with start=0 for 50 cycles -> dout is unchanged and done stays 0.

Source files
------------

// File: rtl/aes_round_seq_if.sv
// aes_round_seq_if
//   Bundles every non-clock signal of the AES round sequencer.
//   Host handshake : start, din (to sequencer); ready, busy, done, dout (from it)
//   Round-key RAM  : key_addr (from sequencer); key_data (to it)
//   Round datapath : rnd_in, rnd_key, rnd_last (from sequencer); rnd_out (to it)
//   modport slave  : the sequencer's view
//   modport master : the surrounding system's view (host, key RAM, datapath)
interface aes_round_seq_if;
  logic         start;
  logic         ready;
  logic [127:0] din;
  logic         busy;
  logic         done;
  logic [127:0] dout;
  logic [3:0]   key_addr;
  logic [127:0] key_data;
  logic [127:0] rnd_in;
  logic [127:0] rnd_key;
  logic         rnd_last;
  logic [127:0] rnd_out;

  modport slave (
    input  start, din, key_data, rnd_out,
    output ready, busy, done, dout, key_addr, rnd_in, rnd_key, rnd_last
  );

  modport master (
    output start, din, key_data, rnd_out,
    input  ready, busy, done, dout, key_addr, rnd_in, rnd_key, rnd_last
  );
endinterface

// File: rtl/aes_round_seq.sv
// aes_round_seq
//   Sequencer for an iterative AES-128 encryption core. Accepts one plaintext
//   block, applies the initial AddRoundKey itself, then drives NR passes through
//   an external round datapath, fetching round keys from a round-key RAM, and
//   returns the ciphertext with a one-cycle done pulse.
// Parameters
//   NR      : number of rounds (1..15)
//   RND_LAT : round datapath latency in cycles (0..7)
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any block in flight
//   bus : aes_round_seq_if.slave (handshake, key RAM and datapath signals)
module aes_round_seq #(
  parameter int NR      = 10,
  parameter int RND_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  aes_round_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  localparam logic [3:0] NR_L  = 4'(NR);
  localparam logic [2:0] LAT_L = 3'(RND_LAT);

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] dout_q, dout_d;
  logic [3:0]   key_addr_q, key_addr_d;
  logic [3:0]   r_q, r_d;
  logic [2:0]   c_q, c_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         rnd_last_q, rnd_last_d;

  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    key_addr_d = key_addr_q;
    r_d        = r_q;
    c_d        = c_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          st_d       = bus.din;
          key_addr_d = 4'd0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        st_d       = st_q ^ bus.key_data;
        key_addr_d = 4'd1;
        r_d        = 4'd1;
        c_d        = 3'd0;
        state_d    = ROUND;
      end

      ROUND: begin
        // st and key_addr stay frozen until the capture cycle so the datapath
        // sees stable operands for the full round.
        if (c_q == LAT_L) begin
          st_d = bus.rnd_out;
          c_d  = 3'd0;
          if (r_q == NR_L) begin
            state_d = DONE;
          end else begin
            r_d        = r_q + 4'd1;
            key_addr_d = r_q + 4'd1;
          end
        end else begin
          c_d = c_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    ready_d    = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    dout_d     = (state_d == DONE) ? st_d : dout_q;
    rnd_last_d = (state_d == ROUND) && (r_d == NR_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      st_q       <= '0;
      dout_q     <= '0;
      key_addr_q <= 4'd0;
      r_q        <= 4'd0;
      c_q        <= 3'd0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rnd_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      dout_q     <= dout_d;
      key_addr_q <= key_addr_d;
      r_q        <= r_d;
      c_q        <= c_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rnd_last_q <= rnd_last_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dout     = dout_q;
  assign bus.key_addr = key_addr_q;
  assign bus.rnd_in   = st_q;
  assign bus.rnd_key  = bus.key_data;
  assign bus.rnd_last = rnd_last_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq
//   Testbench for aes_round_seq. Two instances share clock, reset and a
//   round-key RAM model: dut_a uses RND_LAT=2 behind a two-stage pipelined
//   round model, dut_b uses RND_LAT=0 behind a purely combinational round.
//   Expected ciphertexts come from a plain AES-128 model plus the FIPS-197
//   C.1 vector.
module tb_aes_round_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_seq_if if_a ();
  aes_round_seq_if if_b ();

  aes_round_seq #(.NR(10), .RND_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  aes_round_seq #(.NR(10), .RND_LAT(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk     [16];
  logic [127:0] pipe_a [2];

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] a;
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      a   = 8'(v);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, a);
      if (v == 0) inv = 8'h00;
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // One AES round on a column-major state: byte i lives at bits [127-8i -: 8].
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = b[r + 4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, rk[r], r == 10);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- key RAM and round datapath models ----------------
  assign if_a.key_data = rk[if_a.key_addr];
  assign if_b.key_data = rk[if_b.key_addr];

  // Result appears RND_LAT=2 cycles after the operands it was computed from.
  always @(posedge clk) begin
    pipe_a[0] <= aes_round(if_a.rnd_in, if_a.rnd_key, if_a.rnd_last);
    pipe_a[1] <= pipe_a[0];
  end
  assign if_a.rnd_out = pipe_a[1];
  assign if_b.rnd_out = aes_round(if_b.rnd_in, if_b.rnd_key, if_b.rnd_last);

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle (cycle 0). Returns on the done cycle, or after
  // 100 cycles with cyc=-1.
  task automatic run_block(input bit use_b, input logic [127:0] pt,
                           output int cyc, output logic [127:0] d);
    if (use_b) begin if_b.din = pt; if_b.start = 1'b1; end
    else       begin if_a.din = pt; if_a.start = 1'b1; end
    tick();
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    cyc = -1;
    d   = '0;
    for (int n = 1; n <= 100; n++) begin
      if ((use_b ? if_b.done : if_a.done) === 1'b1) begin
        cyc = n;
        d   = use_b ? if_b.dout : if_a.dout;
        break;
      end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    if_a.start = 1'b0; if_a.din = '0;
    if_b.start = 1'b0; if_b.din = '0;
    repeat (3) tick();
    checks++; if (if_a.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b want 1", if_a.ready); end
    checks++; if (if_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", if_a.busy); end
    checks++; if (if_a.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", if_a.done); end
    checks++; if (if_a.dout !== 128'h0) begin failures++; $display("[TB] FAIL reset_dout: got %h want 0", if_a.dout); end
    checks++; if (if_a.key_addr !== 4'd0) begin failures++; $display("[TB] FAIL reset_key_addr: got %0d want 0", if_a.key_addr); end
    checks++; if (if_a.rnd_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_rnd_last: got %b want 0", if_a.rnd_last); end
    checks++; if (if_a.rnd_in !== 128'h0) begin failures++; $display("[TB] FAIL reset_rnd_in: got %h want 0", if_a.rnd_in); end
    checks++; if (if_b.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_b: got %b want 1", if_b.ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_trace();
    logic [3:0] ea;
    logic       el, eb, er, ed;
    load_key(FIPS_KEY);
    checks++; if (if_a.ready !== 1'b1) begin failures++; $display("[TB] FAIL fips_ready_c0: got %b want 1", if_a.ready); end
    if_a.din = FIPS_PT; if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      if (n <= 1)       ea = 4'd0;
      else if (n <= 31) ea = 4'((n - 2) / 3 + 1);
      else              ea = 4'd10;
      el = (n >= 29) && (n <= 31);
      eb = (n <= 32);
      er = (n == 33);
      ed = (n == 32);
      checks++; if (if_a.key_addr !== ea) begin failures++; $display("[TB] FAIL fips_key_addr c%0d: got %0d want %0d", n, if_a.key_addr, ea); end
      checks++; if (if_a.rnd_last !== el) begin failures++; $display("[TB] FAIL fips_rnd_last c%0d: got %b want %b", n, if_a.rnd_last, el); end
      checks++; if (if_a.busy !== eb) begin failures++; $display("[TB] FAIL fips_busy c%0d: got %b want %b", n, if_a.busy, eb); end
      checks++; if (if_a.ready !== er) begin failures++; $display("[TB] FAIL fips_ready c%0d: got %b want %b", n, if_a.ready, er); end
      checks++; if (if_a.done !== ed) begin failures++; $display("[TB] FAIL fips_done c%0d: got %b want %b", n, if_a.done, ed); end
      if (n >= 32) begin
        checks++; if (if_a.dout !== FIPS_CT) begin failures++; $display("[TB] FAIL fips_dout c%0d: got %h want %h", n, if_a.dout, FIPS_CT); end
      end
      if (n < 33) tick();
    end
  endtask

  task automatic test_ignored_start();
    logic [127:0] pt1, pt2, e1, e2, d, d_at_done;
    int           done_cnt, done_cyc, cyc;
    load_key(rand128());
    pt1 = rand128(); pt2 = rand128();
    e1 = aes_encrypt(pt1); e2 = aes_encrypt(pt2);
    if_a.din = pt1; if_a.start = 1'b1;
    tick();
    done_cnt = 0; done_cyc = -1; d_at_done = '0;
    for (int n = 1; n <= 33; n++) begin
      if (if_a.done === 1'b1) begin done_cnt++; done_cyc = n; d_at_done = if_a.dout; end
      if (n == 5 || n == 20 || n == 32) begin if_a.start = 1'b1; if_a.din = rand128(); end
      else if_a.start = 1'b0;
      if (n < 33) tick();
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("[TB] FAIL ignore_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== 32) begin failures++; $display("[TB] FAIL ignore_done_cycle: got %0d want 32", done_cyc); end
    checks++; if (d_at_done !== e1) begin failures++; $display("[TB] FAIL ignore_dout1: got %h want %h", d_at_done, e1); end
    checks++; if (if_a.ready !== 1'b1) begin failures++; $display("[TB] FAIL ignore_ready_c33: got %b want 1", if_a.ready); end
    run_block(1'b0, pt2, cyc, d);
    checks++; if (cyc !== 32) begin failures++; $display("[TB] FAIL ignore_second_cycle: got %0d want 32", cyc); end
    checks++; if (d !== e2) begin failures++; $display("[TB] FAIL ignore_dout2: got %h want %h", d, e2); end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [127:0] pt, e, d;
    int           cyc, seen;
    load_key(rand128());
    pt = rand128();
    if_a.din = pt; if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    checks++; if (if_a.ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready: got %b want 1", if_a.ready); end
    checks++; if (if_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b want 0", if_a.busy); end
    checks++; if (if_a.done !== 1'b0) begin failures++; $display("[TB] FAIL abort_done: got %b want 0", if_a.done); end
    checks++; if (if_a.dout !== 128'h0) begin failures++; $display("[TB] FAIL abort_dout: got %h want 0", if_a.dout); end
    checks++; if (if_a.key_addr !== 4'd0) begin failures++; $display("[TB] FAIL abort_key_addr: got %0d want 0", if_a.key_addr); end
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (if_a.done === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d pulses want 0", seen); end
    pt = rand128();
    e  = aes_encrypt(pt);
    run_block(1'b0, pt, cyc, d);
    checks++; if (cyc !== 32) begin failures++; $display("[TB] FAIL abort_rerun_cycle: got %0d want 32", cyc); end
    checks++; if (d !== e) begin failures++; $display("[TB] FAIL abort_rerun_dout: got %h want %h", d, e); end
    tick();
  endtask

  task automatic test_zero_latency();
    logic [127:0] pt, e, d;
    int           cyc;
    load_key(FIPS_KEY);
    run_block(1'b1, FIPS_PT, cyc, d);
    checks++; if (cyc !== 12) begin failures++; $display("[TB] FAIL lat0_fips_cycle: got %0d want 12", cyc); end
    checks++; if (d !== FIPS_CT) begin failures++; $display("[TB] FAIL lat0_fips_dout: got %h want %h", d, FIPS_CT); end
    tick();
    for (int k = 0; k < 3; k++) begin
      load_key(rand128());
      pt = rand128();
      e  = aes_encrypt(pt);
      run_block(1'b1, pt, cyc, d);
      checks++; if (cyc !== 12) begin failures++; $display("[TB] FAIL lat0_rand%0d_cycle: got %0d want 12", k, cyc); end
      checks++; if (d !== e) begin failures++; $display("[TB] FAIL lat0_rand%0d_dout: got %h want %h", k, d, e); end
      tick();
    end
  endtask

  task automatic test_dout_hold();
    logic [127:0] pt, e, d;
    int           cyc, bad_dout, bad_done;
    load_key(rand128());
    pt = rand128();
    e  = aes_encrypt(pt);
    run_block(1'b0, pt, cyc, d);
    checks++; if (d !== e) begin failures++; $display("[TB] FAIL hold_dout_at_done: got %h want %h", d, e); end
    bad_dout = 0; bad_done = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if_a.din = rand128();
      if_a.start = 1'b0;
      if (if_a.dout !== e) bad_dout++;
      if (if_a.done !== 1'b0) bad_done++;
    end
    checks++; if (bad_dout !== 0) begin failures++; $display("[TB] FAIL hold_dout: %0d cycles changed, want 0, last %h vs %h", bad_dout, if_a.dout, e); end
    checks++; if (bad_done !== 0) begin failures++; $display("[TB] FAIL hold_done: %0d cycles high, want 0", bad_done); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt, e, d;
    int           cyc;
    for (int k = 0; k < 4; k++) begin
      load_key(rand128());
      pt = rand128();
      e  = aes_encrypt(pt);
      run_block(1'b0, pt, cyc, d);
      checks++; if (cyc !== 32) begin failures++; $display("[TB] FAIL b2b%0d_cycle: got %0d want 32", k, cyc); end
      checks++; if (d !== e) begin failures++; $display("[TB] FAIL b2b%0d_dout: got %h want %h", k, d, e); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    if_a.start = 1'b0; if_a.din = '0;
    if_b.start = 1'b0; if_b.din = '0;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    build_sbox();
    test_reset();
    test_fips_trace();
    test_ignored_start();
    test_reset_abort();
    test_zero_latency();
    test_dout_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
